// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiplier sequencer: state codes,
// error codes and a constant-evaluable ceil(log2) helper.
package matmul_pkg;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_HDR_K     = 4'd1;
   localparam logic [3:0] ST_HDR_N     = 4'd2;
   localparam logic [3:0] ST_LOAD_A    = 4'd3;
   localparam logic [3:0] ST_LOAD_B    = 4'd4;
   localparam logic [3:0] ST_RUN       = 4'd5;
   localparam logic [3:0] ST_WAIT_MULT = 4'd6;
   localparam logic [3:0] ST_FETCH     = 4'd7;
   localparam logic [3:0] ST_SEND      = 4'd8;
   localparam logic [3:0] ST_TXWAIT    = 4'd9;
   localparam logic [3:0] ST_ERR_TX    = 4'd10;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_DIM  = 2'b01;
   localparam logic [1:0] ERR_TMO  = 2'b10;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/res_serializer.sv
// Sends a loaded word MSB byte first over the tx_start/tx_busy handshake and
// flags the cycle in which the final byte has been accepted by the transmitter.
module res_serializer
   import matmul_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int RES_BYTES = 3
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load_i,
   input  logic [DATA_W*RES_BYTES-1:0] word_i,
   input  logic                        single_i,
   input  logic                        tx_busy_i,
   output logic                        tx_start_o,
   output logic [DATA_W-1:0]           tx_data_o,
   output logic                        last_sent_o
);

   localparam int WORD_W = DATA_W * RES_BYTES;
   localparam int BC_W   = clog2(RES_BYTES + 1);

   logic [3:0]        st_q, st_d;
   logic [WORD_W-1:0] sh_q, sh_d;
   logic [BC_W-1:0]   bcnt_q, bcnt_d;
   logic              hold_q, hold_d;
   logic              txs_q, txs_d;
   logic [DATA_W-1:0] txd_q, txd_d;

   always_comb begin
      st_d        = st_q;
      sh_d        = sh_q;
      bcnt_d      = bcnt_q;
      hold_d      = hold_q;
      txs_d       = 1'b0;
      txd_d       = txd_q;
      last_sent_o = 1'b0;
      case (st_q)
         ST_SEND: begin
            if (!tx_busy_i) begin
               txs_d  = 1'b1;
               txd_d  = sh_q[WORD_W-1 -: DATA_W];
               hold_d = 1'b1;
               st_d   = ST_TXWAIT;
            end
         end
         ST_TXWAIT: begin
            // tx_busy may not have risen yet in the cycle tx_start is seen
            if (hold_q) begin
               hold_d = 1'b0;
            end else if (!tx_busy_i) begin
               if (bcnt_q != '0) begin
                  sh_d   = sh_q << DATA_W;
                  bcnt_d = bcnt_q - 1'b1;
                  st_d   = ST_SEND;
               end else begin
                  last_sent_o = 1'b1;
                  st_d        = ST_IDLE;
               end
            end
         end
         default: begin
            if (load_i) begin
               sh_d   = word_i;
               bcnt_d = single_i ? '0 : BC_W'(RES_BYTES - 1);
               st_d   = ST_SEND;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q   <= ST_IDLE;
         sh_q   <= '0;
         bcnt_q <= '0;
         hold_q <= 1'b0;
         txs_q  <= 1'b0;
         txd_q  <= '0;
      end else begin
         st_q   <= st_d;
         sh_q   <= sh_d;
         bcnt_q <= bcnt_d;
         hold_q <= hold_d;
         txs_q  <= txs_d;
         txd_q  <= txd_d;
      end
   end

   assign tx_start_o = txs_q;
   assign tx_data_o  = txd_q;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the UART-fed matrix multiplier: M/K/N header, operand loading,
// multiplier handshake and byte-serial result return with error reporting.
module matmul_seq_ctrl
   import matmul_pkg::*;
#(
   parameter int                DATA_W      = 8,
   parameter int                MAX_DIM     = 8,
   parameter int                ADDR_W      = clog2(MAX_DIM * MAX_DIM),
   parameter int                RES_BYTES   = 3,
   parameter int                TIMEOUT_CYC = 1000000,
   parameter logic [DATA_W-1:0] ERR_CODE    = 8'hEE
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rx_valid,
   input  logic [DATA_W-1:0]           rx_data,
   input  logic                        tx_busy,
   output logic                        tx_start,
   output logic [DATA_W-1:0]           tx_data,
   output logic                        a_we,
   output logic                        b_we,
   output logic [ADDR_W-1:0]           wr_addr,
   output logic [DATA_W-1:0]           wr_data,
   output logic [3:0]                  dim_m,
   output logic [3:0]                  dim_k,
   output logic [3:0]                  dim_n,
   output logic                        mult_start,
   input  logic                        mult_done,
   output logic [ADDR_W-1:0]           res_rd_addr,
   input  logic [DATA_W*RES_BYTES-1:0] res_rd_data,
   output logic                        busy,
   output logic [1:0]                  err
);

   localparam int               WORD_W   = DATA_W * RES_BYTES;
   localparam int               TMO_W    = clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   function automatic logic dim_ok(input logic [DATA_W-1:0] b);
      return (b != '0) && (b <= DATA_W'(MAX_DIM));
   endfunction

   function automatic logic [ADDR_W:0] dim_mul(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = {4'd0, a} * {4'd0, b};
      return (ADDR_W + 1)'(p);
   endfunction

   logic [3:0]        st_q, st_d;
   logic [1:0]        err_q, err_d;
   logic [3:0]        dm_q, dm_d, dk_q, dk_d, dn_q, dn_d;
   logic [ADDR_W:0]   tota_q, tota_d, totb_q, totb_d, mn_q, mn_d;
   logic [ADDR_W-1:0] idx_q, idx_d, ridx_q, ridx_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              ph_q, ph_d;
   logic              wea_q, wea_d, web_q, web_d;
   logic [ADDR_W-1:0] wa_q, wa_d;
   logic [DATA_W-1:0] wd_q, wd_d;

   logic              go_err;
   logic              ser_load, ser_single, ser_last;
   logic [WORD_W-1:0] ser_word;

   always_comb begin
      st_d       = st_q;
      err_d      = err_q;
      dm_d       = dm_q;
      dk_d       = dk_q;
      dn_d       = dn_q;
      tota_d     = tota_q;
      totb_d     = totb_q;
      mn_d       = mn_q;
      idx_d      = idx_q;
      ridx_d     = ridx_q;
      tmo_d      = '0;
      ph_d       = 1'b0;
      wea_d      = 1'b0;
      web_d      = 1'b0;
      wa_d       = wa_q;
      wd_d       = wd_q;
      go_err     = 1'b0;
      ser_load   = 1'b0;
      ser_single = 1'b0;
      ser_word   = res_rd_data;
      case (st_q)
         ST_IDLE: begin
            if (rx_valid) begin
               err_d = ERR_NONE;
               if (dim_ok(rx_data)) begin
                  dm_d = rx_data[3:0];
                  st_d = ST_HDR_K;
               end else begin
                  err_d  = ERR_DIM;
                  go_err = 1'b1;
               end
            end
         end
         ST_HDR_K, ST_HDR_N, ST_LOAD_A, ST_LOAD_B: begin
            // a byte arriving on the expiry cycle still counts
            if (!rx_valid) begin
               if (tmo_q == TMO_LAST) begin
                  err_d  = ERR_TMO;
                  go_err = 1'b1;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end else if (st_q == ST_HDR_K || st_q == ST_HDR_N) begin
               if (!dim_ok(rx_data)) begin
                  err_d  = ERR_DIM;
                  go_err = 1'b1;
               end else if (st_q == ST_HDR_K) begin
                  dk_d = rx_data[3:0];
                  st_d = ST_HDR_N;
               end else begin
                  dn_d   = rx_data[3:0];
                  tota_d = dim_mul(dm_q, dk_q);
                  totb_d = dim_mul(dk_q, rx_data[3:0]);
                  mn_d   = dim_mul(dm_q, rx_data[3:0]);
                  idx_d  = '0;
                  st_d   = ST_LOAD_A;
               end
            end else begin
               wea_d = (st_q == ST_LOAD_A);
               web_d = (st_q == ST_LOAD_B);
               wa_d  = idx_q;
               wd_d  = rx_data;
               if ({1'b0, idx_q} == ((st_q == ST_LOAD_A) ? tota_q : totb_q) - 1'b1) begin
                  idx_d = '0;
                  st_d  = (st_q == ST_LOAD_A) ? ST_LOAD_B : ST_RUN;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_RUN: st_d = ST_WAIT_MULT;
         ST_WAIT_MULT: begin
            if (mult_done) begin
               ridx_d = '0;
               st_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            // first cycle presents the address, second cycle captures the word
            if (!ph_q) begin
               ph_d = 1'b1;
            end else begin
               ser_load = 1'b1;
               st_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            if (ser_last) begin
               if ({1'b0, ridx_q} == mn_q - 1'b1) begin
                  st_d = ST_IDLE;
               end else begin
                  ridx_d = ridx_q + 1'b1;
                  st_d   = ST_FETCH;
               end
            end
         end
         ST_ERR_TX: if (ser_last) st_d = ST_IDLE;
         default: st_d = ST_IDLE;
      endcase
      if (go_err) begin
         st_d       = ST_ERR_TX;
         ser_load   = 1'b1;
         ser_single = 1'b1;
         ser_word   = '0;
         ser_word[WORD_W-1 -: DATA_W] = ERR_CODE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q   <= ST_IDLE;
         err_q  <= ERR_NONE;
         dm_q   <= '0;
         dk_q   <= '0;
         dn_q   <= '0;
         tota_q <= '0;
         totb_q <= '0;
         mn_q   <= '0;
         idx_q  <= '0;
         ridx_q <= '0;
         tmo_q  <= '0;
         ph_q   <= 1'b0;
         wea_q  <= 1'b0;
         web_q  <= 1'b0;
         wa_q   <= '0;
         wd_q   <= '0;
      end else begin
         st_q   <= st_d;
         err_q  <= err_d;
         dm_q   <= dm_d;
         dk_q   <= dk_d;
         dn_q   <= dn_d;
         tota_q <= tota_d;
         totb_q <= totb_d;
         mn_q   <= mn_d;
         idx_q  <= idx_d;
         ridx_q <= ridx_d;
         tmo_q  <= tmo_d;
         ph_q   <= ph_d;
         wea_q  <= wea_d;
         web_q  <= web_d;
         wa_q   <= wa_d;
         wd_q   <= wd_d;
      end
   end

   res_serializer #(
      .DATA_W   (DATA_W),
      .RES_BYTES(RES_BYTES)
   ) u_ser (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ser_load),
      .word_i     (ser_word),
      .single_i   (ser_single),
      .tx_busy_i  (tx_busy),
      .tx_start_o (tx_start),
      .tx_data_o  (tx_data),
      .last_sent_o(ser_last)
   );

   assign a_we        = wea_q;
   assign b_we        = web_q;
   assign wr_addr     = wa_q;
   assign wr_data     = wd_q;
   assign dim_m       = dm_q;
   assign dim_k       = dk_q;
   assign dim_n       = dn_q;
   assign mult_start  = (st_q == ST_RUN);
   assign res_rd_addr = ridx_q;
   assign busy        = (st_q != ST_IDLE);
   assign err         = err_q;

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Parametrised sequencer for the UART-fed matrix multiplier, replacing the square-only controller. It receives a three-byte header (M, K, N) and writes matrix A (M×K) and matrix B (K×N) into the operand buffers with explicit addresses. It then runs the multiplier and streams the M×N result back through the UART transmitter, sending each element as several bytes. It adds dimension checking, inter-byte timeout and error reporting.

Parameters:
DATA_W, 8, UART byte / operand element width
MAX_DIM, 8, largest legal M, K or N (2..15)
ADDR_W, 6, buffer address width; must satisfy 2^ADDR_W >= MAX_DIM*MAX_DIM
RES_BYTES, 3, bytes per result element, sent MSB first
TIMEOUT_CYC, 1000000, idle cycles allowed between received bytes before abort
ERR_CODE, 8'hEE, byte transmitted on any error

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rx_valid  in  1  one-cycle strobe; rx_data valid
rx_data  in  DATA_W  received byte
tx_busy  in  1  transmitter busy
tx_start  out  1  one-cycle transmit request
tx_data  out  DATA_W  byte to transmit; valid while tx_start=1
a_we  out  1  write strobe, A buffer
b_we  out  1  write strobe, B buffer
wr_addr  out  ADDR_W  linear row-major write index
wr_data  out  DATA_W  write data (registered rx_data)
dim_m, dim_k, dim_n  out  4 each  latched dimensions, for the multiplier
mult_start  out  1  one-cycle start pulse
mult_done  in  1  multiplier finished (level or pulse)
res_rd_addr  out  ADDR_W  result buffer read index
res_rd_data  in  8*RES_BYTES  result element; 1-cycle read latency
busy  out  1  high in every state except IDLE
err  out  2  00 none, 01 bad dimension, 10 timeout; sticky until next valid M byte

Behaviour:
- Reset: every output is 0, state IDLE, all counters 0. Reset mid-operation aborts immediately and sends no error byte.
- States: IDLE, HDR_K, HDR_N, LOAD_A, LOAD_B, RUN, WAIT_MULT, FETCH, SEND, TXWAIT, ERR_TX.
- IDLE: on rx_valid, latch M and clear err.
  - Byte 0 or > MAX_DIM: err=01, go to ERR_TX.
  - Otherwise go to HDR_K.
- HDR_K, HDR_N: same check per byte. After a legal N, register totA=M*K and totB=K*N, then enter LOAD_A with idx=0.
- LOAD_A: each rx_valid gives one cycle later a_we=1, wr_addr=idx, wr_data=byte, then idx++. When the write with idx=totA-1 issues, set idx=0 and go to LOAD_B.
- LOAD_B: same with b_we and totB. After the last write go to RUN.
- RUN: mult_start=1 for exactly one cycle, then WAIT_MULT. mult_done is sampled only in WAIT_MULT, so a done asserted coincident with the start is ignored.
- WAIT_MULT: on mult_done, set ridx=0 and go to FETCH.
- FETCH: drive res_rd_addr=ridx. Capture res_rd_data the next cycle into a shift register and set bcnt=RES_BYTES-1.
- SEND: when tx_busy=0, pulse tx_start with tx_data = current top byte, then go to TXWAIT.
- TXWAIT: ignore tx_busy for one cycle, then wait for tx_busy=0.
  - If bytes remain: shift and return to SEND.
  - Else if ridx=M*N-1: go to IDLE.
  - Else: ridx++ and go to FETCH.
- Timeout: in HDR_K, HDR_N, LOAD_A and LOAD_B, a counter clears on every rx_valid. When it reaches TIMEOUT_CYC-1 with no rx_valid: err=10, go to ERR_TX. rx_valid in the same cycle wins over timeout.
- ERR_TX: send ERR_CODE once using the SEND/TXWAIT handshake, then go to IDLE. rx bytes arriving in ERR_TX, RUN, WAIT_MULT, FETCH, SEND or TXWAIT are dropped.
- Widths: totA, totB and M*N are ADDR_W+1 bits wide; no wrap inside the legal range. The 1×1×1 case gives one write to each buffer and RES_BYTES transmitted bytes.
- tx_start is never asserted on two consecutive cycles.

Decomposition:
- Package matmul_pkg: the state enumeration, ERR_* codes, and a clog2 function for deriving ADDR_W and the timeout counter width.
- One sub-module, res_serializer: loads a RES_BYTES-wide word, runs the SEND/TXWAIT byte handshake, and reports "last byte sent". The control FSM reuses it for ERR_TX by loading ERR_CODE as a one-byte word.

Test Plan:
- Header 2,3,2, then A = 1..6, B = 7..12 -> a_we at addrs 0..5 with data 1..6, b_we at 0..5 with data 7..12, exactly one mult_start.
- Same run with result word i = 0x010203+i, RES_BYTES=3, tx_busy high 10 cycles per byte -> 12 bytes transmitted: 01 02 03, 01 02 04, ..., in order, then busy=0.
- Header byte 9 with MAX_DIM=8 -> err=01, single tx byte 0xEE, return to IDLE; a following legal header clears err to 00.
- TIMEOUT_CYC=50, stop after 3 A bytes -> exactly 50 idle cycles later err=10, 0xEE sent, no mult_start.
- 1×1×1 header, A=5, B=7 -> one write each, RES_BYTES tx bytes; mult_done held high through RUN does not skip WAIT_MULT.
- Assert rst during SEND -> tx_start=0 and all outputs 0 the same cycle; a new header is accepted after reset release.
